btn_debounce_multi: RTL and testbench
=====================================

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 Parameter NUM_BTN, default 5: number of independent button channels, range 1..32.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-003 Parameter F_TICK, default 1_000_000: sample tick rate in Hz; F_COUNT = CLK_FREQ/F_TICK, F_COUNT >= 2.
REQ-004 Parameter NUM_DEB, default 16: consecutive stable ticks needed to accept a press or a release, >= 2.
REQ-005 Parameter LONG_TICKS, default 500_000: held ticks from accepted press to the long-press event, >= 1.
REQ-006 Parameter REPEAT_TICKS, default 100_000: held ticks between auto-repeat events after long press; 0 disables repeat.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 i_btn  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-010 o_level  output  NUM_BTN  debounced level per channel.
REQ-011 o_press  output  NUM_BTN  one-clock pulse on accepted press.
REQ-012 o_release  output  NUM_BTN  one-clock pulse on accepted release.
REQ-013 o_long  output  NUM_BTN  one-clock pulse once per hold at LONG_TICKS.
REQ-014 o_repeat  output  NUM_BTN  one-clock pulse every REPEAT_TICKS after o_long while held.

Function
REQ-015 Each i_btn bit SHALL pass through a 2-flop synchronizer; "sync" below means the second flop output.
REQ-016 One shared tick counter SHALL count 0..F_COUNT-1 and wrap; a registered tick SHALL be high for exactly the one cycle after each wrap, first at cycle F_COUNT after reset deassertion.
REQ-017 Each channel SHALL run an independent FSM: IDLE, DEB_PRESS, HELD, DEB_RELEASE, with a debounce counter of width $clog2(NUM_DEB) and a hold counter wide enough for max(LONG_TICKS, REPEAT_TICKS).
REQ-018 IDLE: debounce counter = 0; sync=1 -> DEB_PRESS (checked every clock, not only on tick).
REQ-019 DEB_PRESS, on tick: sync=0 -> IDLE; sync=1 and counter = NUM_DEB-1 -> HELD; else counter+1. No action on non-tick cycles.
REQ-020 Entry to HELD from DEB_PRESS SHALL set o_level=1 and pulse o_press for exactly one cycle (the first cycle in HELD), and clear the hold counter.
REQ-021 HELD, on tick with sync=1: hold counter+1; o_long pulses when the counter reaches LONG_TICKS, once per hold.
REQ-022 After o_long, with REPEAT_TICKS>0, the hold counter SHALL restart at 0 and o_repeat pulse each time it reaches REPEAT_TICKS, restarting again; with REPEAT_TICKS=0 the counter saturates and o_repeat stays 0.
REQ-023 HELD with sync=0 on any clock -> DEB_RELEASE, debounce counter = 0; o_level stays 1.
REQ-024 DEB_RELEASE, on tick: sync=1 -> HELD without o_press and with hold counter and long/repeat progress preserved; sync=0 and counter = NUM_DEB-1 -> IDLE; else counter+1.
REQ-025 Entry to IDLE from DEB_RELEASE SHALL clear o_level and pulse o_release for one cycle; hold progress cleared.
REQ-026 Hold counter SHALL NOT advance in DEB_RELEASE.
REQ-027 All outputs SHALL be registered; o_press, o_release, o_long, o_repeat never high two consecutive cycles on one channel, and o_press/o_release never together on one channel.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-029 Input-to-o_press latency: 2 sync cycles + NUM_DEB ticks (±1 tick phase) + 1 cycle.

Reset
REQ-030 With reset high at a rising edge: tick counter, tick, synchronizers, all FSMs (IDLE), all counters and all outputs SHALL be 0 on the next cycle.
REQ-031 Reset mid-debounce or mid-hold SHALL abandon the operation with no pulse; a button still pressed after reset SHALL be re-debounced from IDLE and produce a fresh o_press.

Verification (CLK_FREQ=100, F_TICK=10 -> F_COUNT=10; NUM_DEB=4; LONG_TICKS=8; REPEAT_TICKS=3; NUM_BTN=2)
REQ-032 Bench: i_btn[0]=1 held steady -> single o_press[0] pulse and o_level[0]=1 after 4 ticks (~42 cycles); no other outputs.
REQ-033 Bench: i_btn[0] glitch high for 25 cycles then low -> no o_press, o_level stays 0, FSM back in IDLE.
REQ-034 Bench: hold i_btn[1] 20 ticks past press -> o_long[1] at hold tick 8, o_repeat[1] at hold ticks 11, 14, 17, 20; then release -> o_release[1] after 4 ticks, o_level[1]=0.
REQ-035 Bench: while HELD, drop i_btn[0] for 15 cycles -> no o_release, no second o_press, long/repeat timing shifted only by ticks spent in DEB_RELEASE.
REQ-036 Bench: both buttons pressed same cycle -> o_press=2'b11 in one cycle; reset asserted mid-hold -> all outputs 0 next cycle, then fresh o_press after re-debounce.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer with a shared sample tick, press/release
// pulses, a long-press event and optional auto-repeat while held.
module btn_debounce_multi #(
  parameter int NUM_BTN      = 5,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int F_TICK       = 1_000_000,
  parameter int NUM_DEB      = 16,
  parameter int LONG_TICKS   = 500_000,
  parameter int REPEAT_TICKS = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [NUM_BTN-1:0] o_long,
  output logic [NUM_BTN-1:0] o_repeat
);

  localparam int F_COUNT  = CLK_FREQ / F_TICK;
  localparam int TICK_W   = $clog2(F_COUNT);
  localparam int DEB_W    = $clog2(NUM_DEB);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(F_COUNT - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(NUM_DEB - 1);
  localparam logic [HOLD_W-1:0] LONG_AT   = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] REP_AT    = HOLD_W'(REPEAT_TICKS);
  localparam bit                REP_EN    = (REPEAT_TICKS > 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [NUM_BTN-1:0] btn_p0;
  logic [NUM_BTN-1:0] btn_p1;

  // Shared sample tick: registered, high for the one cycle after each wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  // Stage p0 -> p1: two-flop synchronizer for the raw button levels
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= i_btn;
      btn_p1 <= btn_p0;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t             state_q, state_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
    logic               long_done_q, long_done_d;
    logic               level_q, press_q, release_q, long_q, repeat_q;
    logic               level_d, press_d, release_d, long_d, repeat_d;
    logic               sync;

    assign sync     = btn_p1[g];
    assign hold_inc = hold_q + 1'b1;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= IDLE;
        deb_q       <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_q       <= deb_d;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      case (state_q)
        IDLE: begin
          deb_d       = '0;
          hold_d      = '0;
          long_done_d = 1'b0;
          if (sync) state_d = DEB_PRESS;
        end
        DEB_PRESS: begin
          if (tick) begin
            if (!sync) begin
              state_d = IDLE;
            end else if (deb_q == DEB_LAST) begin
              state_d     = HELD;
              hold_d      = '0;
              long_done_d = 1'b0;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (!sync) begin
            state_d = DEB_RELEASE;
            deb_d   = '0;
          end else if (tick) begin
            // Before the long event count toward LONG_TICKS; afterwards
            // either cycle through REPEAT_TICKS or park the counter.
            if (!long_done_q) begin
              if (hold_inc == LONG_AT) begin
                long_done_d = 1'b1;
                hold_d      = REP_EN ? '0 : hold_inc;
              end else begin
                hold_d = hold_inc;
              end
            end else if (REP_EN) begin
              hold_d = (hold_inc == REP_AT) ? '0 : hold_inc;
            end
          end
        end
        DEB_RELEASE: begin
          if (tick) begin
            if (sync) begin
              state_d = HELD;
            end else if (deb_q == DEB_LAST) begin
              state_d     = IDLE;
              hold_d      = '0;
              long_done_d = 1'b0;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      level_d   = (state_d == HELD) || (state_d == DEB_RELEASE);
      press_d   = (state_q == DEB_PRESS) && (state_d == HELD);
      release_d = (state_q == DEB_RELEASE) && (state_d == IDLE);
      long_d    = (state_q == HELD) && !long_done_q && long_done_d;
      repeat_d  = REP_EN && (state_q == HELD) && sync && tick && long_done_q &&
                  (hold_inc == REP_AT);
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
    assign o_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: timed vector table, hand-written reset and
// simultaneous-press sequences, and randomized bouncy input against a model.
module tb_btn_debounce_multi;
  localparam int NB           = 2;
  localparam int CLK_FREQ     = 100;
  localparam int F_TICK       = 10;
  localparam int NUM_DEB      = 4;
  localparam int LONG_TICKS   = 8;
  localparam int REPEAT_TICKS = 3;
  localparam int F_COUNT      = CLK_FREQ / F_TICK;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] i_btn = '0;
  logic [NB-1:0] o_level, o_press, o_release, o_long, o_repeat;

  btn_debounce_multi #(
    .NUM_BTN(NB), .CLK_FREQ(CLK_FREQ), .F_TICK(F_TICK), .NUM_DEB(NUM_DEB),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn), .o_level(o_level),
    .o_press(o_press), .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks accepted level plus a pending count of agreeing
  // sample ticks; tick instants come from the cycle count since reset.
  int            m_cyc;
  logic [NB-1:0] m_s1, m_s2;
  bit            m_lvl [NB];
  int            m_pend[NB];
  int            m_held[NB];
  bit            m_ldone[NB];
  logic [NB-1:0] e_lvl = '0, e_pr = '0, e_rl = '0, e_lg = '0, e_rp = '0;

  task automatic model_step();
    bit tk;
    bit sy;
    if (reset) begin
      m_cyc = 0;
      m_s1  = '0;
      m_s2  = '0;
      e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
      for (int c = 0; c < NB; c++) begin
        m_lvl[c] = 1'b0; m_pend[c] = -1; m_held[c] = 0; m_ldone[c] = 1'b0;
      end
    end else begin
      tk = (m_cyc > 0) && (m_cyc % F_COUNT == 0);
      e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
      for (int c = 0; c < NB; c++) begin
        sy = m_s2[c];
        if (!m_lvl[c]) begin
          if (m_pend[c] < 0) begin
            if (sy) m_pend[c] = 0;
          end else if (tk) begin
            if (!sy) m_pend[c] = -1;
            else if (m_pend[c] == NUM_DEB - 1) begin
              m_lvl[c] = 1'b1; m_pend[c] = -1; m_held[c] = 0; m_ldone[c] = 1'b0;
              e_pr[c] = 1'b1;
            end else m_pend[c]++;
          end
        end else begin
          if (m_pend[c] < 0) begin
            if (!sy) m_pend[c] = 0;
            else if (tk) begin
              m_held[c]++;
              if (!m_ldone[c] && m_held[c] == LONG_TICKS) begin
                e_lg[c] = 1'b1; m_ldone[c] = 1'b1;
                if (REPEAT_TICKS > 0) m_held[c] = 0;
              end else if (m_ldone[c] && REPEAT_TICKS > 0 && m_held[c] == REPEAT_TICKS) begin
                e_rp[c] = 1'b1; m_held[c] = 0;
              end
            end
          end else if (tk) begin
            if (sy) m_pend[c] = -1;
            else if (m_pend[c] == NUM_DEB - 1) begin
              m_lvl[c] = 1'b0; m_pend[c] = -1; m_held[c] = 0; m_ldone[c] = 1'b0;
              e_rl[c] = 1'b1;
            end else m_pend[c]++;
          end
        end
        e_lvl[c] = m_lvl[c];
      end
      m_s2 = m_s1;
      m_s1 = i_btn;
      m_cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("model", 64'({o_level, o_press, o_release, o_long, o_repeat}),
            64'({e_lvl, e_pr, e_rl, e_lg, e_rp}));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  // Counts are nibble-packed per channel: [3:0] = channel 0, [7:4] = channel 1.
  typedef struct {
    bit         rst;
    logic [1:0] btn;
    int         cyc;
    logic [1:0] lvl;
    logic [7:0] pr, rl, lg, rp;
  } vec_t;

  function automatic vec_t row(bit rst, logic [1:0] btn, int cyc, logic [1:0] lvl,
                               logic [7:0] pr, logic [7:0] rl, logic [7:0] lg, logic [7:0] rp);
    vec_t v;
    v.rst = rst; v.btn = btn; v.cyc = cyc; v.lvl = lvl;
    v.pr = pr; v.rl = rl; v.lg = lg; v.rp = rp;
    return v;
  endfunction

  // Called just after a negedge; the next posedge is the first after release.
  task automatic do_reset(input logic [1:0] btn);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    i_btn = btn;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic [7:0] cp, cr, cl, cq;
    cp = '0; cr = '0; cl = '0; cq = '0;
    if (v.rst) do_reset(v.btn);
    else i_btn = v.btn;
    for (int k = 0; k < v.cyc; k++) begin
      @(posedge clk); @(negedge clk);
      cp = cp + {3'b0, o_press[1], 3'b0, o_press[0]};
      cr = cr + {3'b0, o_release[1], 3'b0, o_release[0]};
      cl = cl + {3'b0, o_long[1], 3'b0, o_long[0]};
      cq = cq + {3'b0, o_repeat[1], 3'b0, o_repeat[0]};
    end
    check($sformatf("row%0d", idx), 64'({o_level, cp, cr, cl, cq}),
          64'({v.lvl, v.pr, v.rl, v.lg, v.rp}));
  endtask

  vec_t          tbl[$];
  int            first_k;
  logic [1:0]    first_v;
  logic [1:0]    other;
  logic [NB-1:0] tgt;
  int            bnc[NB];

  initial begin
    // Steady press on ch0, then clean release
    tbl.push_back(row(1, 2'b01,  40, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,   2, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,  60, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b00,  38, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b00,   2, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00));
    // 25-cycle glitch on ch0, then a full-length press proves IDLE was reached
    tbl.push_back(row(1, 2'b01,  25, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b00,  40, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,  35, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,   2, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00));
    // ch1 held 20 ticks: long at tick 8, repeats at 11/14/17/20, then release
    tbl.push_back(row(1, 2'b10,  40, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b10,   2, 2'b10, 8'h10, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b10,  78, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b10,   2, 2'b10, 8'h00, 8'h00, 8'h10, 8'h00));
    tbl.push_back(row(0, 2'b10, 120, 2'b10, 8'h00, 8'h00, 8'h00, 8'h40));
    tbl.push_back(row(0, 2'b00,  38, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b00,   2, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00));
    // ch0 drops 15 cycles while held: two hold ticks lost, long moves to cycle 141
    tbl.push_back(row(1, 2'b01,  40, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,  22, 2'b01, 8'h01, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b00,  15, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,  63, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(row(0, 2'b01,   2, 2'b01, 8'h00, 8'h00, 8'h01, 8'h00));
    tbl.push_back(row(0, 2'b01,  30, 2'b01, 8'h00, 8'h00, 8'h00, 8'h01));

    reset = 1'b1;
    i_btn = '0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk_en = 1'b1;
    check("reset_state", 64'({o_level, o_press, o_release, o_long, o_repeat}), 64'd0);

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // Both buttons in the same cycle, then reset mid-hold with buttons still down
    do_reset(2'b11);
    first_k = 0; first_v = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (o_press != '0 && first_k == 0) begin first_k = k; first_v = o_press; end
    end
    check("both_press_cycle", 64'(first_k), 64'd41);
    check("both_press_value", 64'(first_v), 64'(2'b11));
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("reset_mid_hold", 64'({o_level, o_press, o_release, o_long, o_repeat}), 64'd0);
    reset = 1'b0;
    first_k = 0; first_v = '0; other = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (o_press != '0 && first_k == 0) begin first_k = k; first_v = o_press; end
      other = other | o_release | o_long | o_repeat;
    end
    check("fresh_press_cycle", 64'(first_k), 64'd41);
    check("fresh_press_value", 64'(first_v), 64'(2'b11));
    check("fresh_no_other", 64'(other), 64'd0);
    check("fresh_level", 64'(o_level), 64'(2'b11));

    // Randomized bouncy buttons with occasional resets
    do_reset(2'b00);
    tgt = '0;
    for (int c = 0; c < NB; c++) bnc[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); @(negedge clk);
      reset = ($urandom_range(0, 1499) == 0);
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          tgt[c] = ~tgt[c];
          bnc[c] = int'($urandom_range(5, 40));
        end
        if (bnc[c] > 0) begin
          bnc[c]--;
          i_btn[c] = ($urandom_range(0, 2) == 0) ? ~tgt[c] : tgt[c];
        end else begin
          i_btn[c] = ($urandom_range(0, 149) == 0) ? ~tgt[c] : tgt[c];
        end
      end
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
